// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: passive monitor that recovers hex digits from a multiplexed active-low 7-segment bus.
// Define SEG7_DP_EN to add decimal-point capture (dp input, dp_out output).
module seg7_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DIGITS-1:0]   an,
  input  logic [6:0]          seg,
`ifdef SEG7_DP_EN
  input  logic                dp,
  output logic [DIGITS-1:0]   dp_out,
`endif
  input  logic                clr,
  output logic [4*DIGITS-1:0] digits_out,
  output logic [DIGITS-1:0]   digit_valid,
  output logic                err,
  output logic                frame_done
);

`ifdef SEG7_DP_EN
  localparam int SW = DIGITS + 8;
`else
  localparam int SW = DIGITS + 7;
`endif
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 2);
  localparam logic [DIGITS-1:0] AN_ONE = DIGITS'(1);

  typedef enum logic [1:0] {S_SETTLE, S_COMMIT, S_HOLD} state_t;

  state_t              r_state;
  logic [SW-1:0]       r_sync1, r_sync2, r_prev;
  logic [CW-1:0]       r_cnt;
  logic [DIGITS-1:0]   r_seen;
  logic [4*DIGITS-1:0] r_digits;
  logic [DIGITS-1:0]   r_valid;
  logic                r_err;
  logic                r_frame;

  logic [SW-1:0]       w_pins;
  logic                w_match;
  logic [DIGITS-1:0]   w_an_low;
  logic [6:0]          w_seg;
  logic                w_an_idle, w_an_one;
  logic [4:0]          w_dec;
  logic                w_legal, w_blank;
  logic                w_commit, w_single, w_bad, w_full;
  logic [DIGITS-1:0]   w_hit, w_valid_next, w_seen_next;
  logic [4*DIGITS-1:0] w_digits_next;
  logic                w_err_next;

`ifdef SEG7_DP_EN
  logic [DIGITS-1:0]   r_dp;
  logic [DIGITS-1:0]   w_dp_next;
  assign w_pins = {dp, an, seg};
  assign dp_out = r_dp;
`else
  assign w_pins = {an, seg};
`endif

  assign w_match   = (r_sync2 == r_prev);
  // r_prev holds the pattern that earned the commit, even if the bus moves during COMMIT
  assign w_an_low  = ~r_prev[DIGITS+6:7];
  assign w_seg     = r_prev[6:0];
  assign w_an_idle = (w_an_low == '0);
  assign w_an_one  = !w_an_idle && ((w_an_low & (w_an_low - AN_ONE)) == '0);

  always_comb begin
    w_dec = 5'h00;
    case (w_seg)
      7'b0000001: w_dec = 5'h10;
      7'b1001111: w_dec = 5'h11;
      7'b0010010: w_dec = 5'h12;
      7'b0000110: w_dec = 5'h13;
      7'b1001100: w_dec = 5'h14;
      7'b0100100: w_dec = 5'h15;
      7'b0100000: w_dec = 5'h16;
      7'b0001111: w_dec = 5'h17;
      7'b0000000: w_dec = 5'h18;
      7'b0000100: w_dec = 5'h19;
      7'b0001000: w_dec = 5'h1A;
      7'b1100000: w_dec = 5'h1B;
      7'b0110001: w_dec = 5'h1C;
      7'b1000010: w_dec = 5'h1D;
      7'b0110000: w_dec = 5'h1E;
      7'b0111000: w_dec = 5'h1F;
      default:    w_dec = 5'h00;
    endcase
  end

  assign w_legal  = w_dec[4];
  assign w_blank  = (w_seg == 7'b1111111);
  // The bus must still match in COMMIT, so a pattern needs STABLE_CYCLES+1 synchronized samples
  assign w_commit = (r_state == S_COMMIT) && w_match;
  assign w_single = w_commit && w_an_one;
  assign w_bad    = w_commit && ((!w_an_idle && !w_an_one) || (w_an_one && !w_legal && !w_blank));
  assign w_full   = (r_seen == '1);

  genvar gi;
  for (gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign w_hit[gi]               = w_single && w_an_low[gi];
    assign w_valid_next[gi]        = w_hit[gi] ? w_legal : (r_valid[gi] && !clr);
    assign w_digits_next[4*gi +: 4] = (w_hit[gi] && w_legal) ? w_dec[3:0] : r_digits[4*gi +: 4];
`ifdef SEG7_DP_EN
    assign w_dp_next[gi]           = w_hit[gi] ? ~r_prev[SW-1] : r_dp[gi];
`endif
  end

  assign w_seen_next = ((clr || w_full) ? '0 : r_seen) | w_hit;
  assign w_err_next  = (r_err && !clr) || w_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= '1;
      r_sync2  <= '1;
      r_prev   <= '1;
      r_cnt    <= '0;
      r_state  <= S_SETTLE;
      r_seen   <= '0;
      r_digits <= '0;
      r_valid  <= '0;
      r_err    <= 1'b0;
      r_frame  <= 1'b0;
`ifdef SEG7_DP_EN
      r_dp     <= '0;
`endif
    end else begin
      r_sync1 <= w_pins;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (!w_match)
        r_cnt <= '0;
      else if (r_cnt != CNT_MAX)
        r_cnt <= r_cnt + CW'(1);
      case (r_state)
        S_SETTLE: if (w_match && r_cnt == CNT_PRE) r_state <= S_COMMIT;
        S_COMMIT: r_state <= w_match ? S_HOLD : S_SETTLE;
        S_HOLD:   if (!w_match) r_state <= S_SETTLE;
        default:  r_state <= S_SETTLE;
      endcase
      r_seen   <= w_seen_next;
      r_digits <= w_digits_next;
      r_valid  <= w_valid_next;
      r_err    <= w_err_next;
      r_frame  <= w_full && !clr;
`ifdef SEG7_DP_EN
      r_dp     <= w_dp_next;
`endif
    end
  end

  assign digits_out  = r_digits;
  assign digit_valid = r_valid;
  assign err         = r_err;
  assign frame_done  = r_frame;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed self-checking bench for seg7_scan_decoder (DIGITS=4, STABLE_CYCLES=16).
`timescale 1ns/1ps
module tb_seg7_scan_decoder;
  localparam int DIGITS        = 4;
  localparam int STABLE_CYCLES = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        clr;
  logic [15:0] digits_out;
  logic [3:0]  digit_valid;
  logic        err;
  logic        frame_done;
`ifdef SEG7_DP_EN
  logic        dp;
  logic [3:0]  dp_out;
`endif

  int n_tests  = 0;
  int n_fail   = 0;
  int n_frames = 0;
  int frames_before;

  seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE_CYCLES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an          (an),
    .seg         (seg),
`ifdef SEG7_DP_EN
    .dp          (dp),
    .dp_out      (dp_out),
`endif
    .clr         (clr),
    .digits_out  (digits_out),
    .digit_valid (digit_valid),
    .err         (err),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done) n_frames++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic show(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    tick(n);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; an = 4'hF; seg = 7'h7F;
`ifdef SEG7_DP_EN
    dp = 1'b1;
`endif
    tick(3);
    check_eq("rst_digits", 32'(digits_out), 32'h0);
    check_eq("rst_valid", 32'(digit_valid), 32'h0);
    check_eq("rst_err", 32'(err), 32'h0);
    check_eq("rst_frame", 32'(frame_done), 32'h0);
`ifdef SEG7_DP_EN
    check_eq("rst_dp", 32'(dp_out), 32'h0);
`endif
    rst_n = 1'b1;
    tick(40);

    // two full scans: digits 3, b, C, 0
    for (int p = 0; p < 2; p++) begin
      show(4'b1110, 7'b0000110, 40);
      show(4'b1101, 7'b1100000, 40);
      show(4'b1011, 7'b0110001, 40);
      show(4'b0111, 7'b0000001, 40);
      if (p == 0) begin
        check_eq("scan_digits", 32'(digits_out), 32'h0CB3);
        check_eq("scan_valid", 32'(digit_valid), 32'hF);
        check_eq("scan_err", 32'(err), 32'h0);
      end
      check_eq("scan_frames", 32'(n_frames), 32'(p + 1));
    end
    show(4'hF, 7'h7F, 40);

    // 16-cycle hold must be rejected
    an = 4'b1110; seg = 7'b0100100; tick(16);
    an = 4'hF; seg = 7'h7F; tick(40);
    check_eq("glitch16", 32'(digits_out[3:0]), 32'h3);

    // 17-cycle hold commits exactly STABLE_CYCLES+3 clocks after the change
    an = 4'b1110; seg = 7'b0100100; tick(17);
    an = 4'hF; seg = 7'h7F; tick(1);
    check_eq("lat_minus1", 32'(digits_out[3:0]), 32'h3);
    tick(1);
    check_eq("lat_exact", 32'(digits_out[3:0]), 32'h5);
    tick(40);

    show(4'b1110, 7'b1111111, 40);
    check_eq("blank_valid0", 32'(digit_valid[0]), 32'h0);
    check_eq("blank_nibble", 32'(digits_out[3:0]), 32'h5);
    check_eq("blank_err", 32'(err), 32'h0);

    show(4'b1101, 7'b1010101, 40);
    check_eq("illegal_err", 32'(err), 32'h1);
    check_eq("illegal_valid", 32'(digit_valid), 32'hC);
    show(4'b1100, 7'b0000001, 40);
    check_eq("multi_an_err", 32'(err), 32'h1);
    check_eq("multi_an_digits", 32'(digits_out), 32'h0CB5);
    clr = 1'b1; tick(1); clr = 1'b0;
    check_eq("clr_err", 32'(err), 32'h0);
    check_eq("clr_valid", 32'(digit_valid), 32'h0);
    check_eq("clr_digits", 32'(digits_out), 32'h0CB5);
    show(4'hF, 7'h7F, 40);

    // clr coinciding with COMMIT: clear first, commit wins for digit 2
    show(4'b1110, 7'b0000001, 40);
    check_eq("pre_clr_valid", 32'(digit_valid), 32'h1);
    an = 4'b1011; seg = 7'b0000000; tick(18);
    clr = 1'b1; tick(1); clr = 1'b0;
    check_eq("clr_commit_valid", 32'(digit_valid), 32'h4);
    check_eq("clr_commit_digits", 32'(digits_out), 32'h08B0);
    tick(21);

    // mask completes, clr in the frame_done cycle suppresses the pulse
    show(4'b1101, 7'b1100000, 40);
    show(4'b0111, 7'b0000001, 40);
    frames_before = n_frames;
    an = 4'b1110; seg = 7'b1001111; tick(19);
    clr = 1'b1; tick(1); clr = 1'b0; tick(20);
    check_eq("frame_clr", 32'(n_frames), 32'(frames_before));
    check_eq("frame_clr_digits", 32'(digits_out), 32'h08B1);
    check_eq("frame_clr_valid", 32'(digit_valid), 32'h0);
    show(4'hF, 7'h7F, 40);

    // reset asserted while in COMMIT
    an = 4'b0111; seg = 7'b1001111; tick(18);
    rst_n = 1'b0; #1;
    check_eq("midrst_digits", 32'(digits_out), 32'h0);
    check_eq("midrst_valid", 32'(digit_valid), 32'h0);
    check_eq("midrst_err", 32'(err), 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(18);
    check_eq("postrst_early", 32'(digits_out), 32'h0);
    tick(1);
    check_eq("postrst_digits", 32'(digits_out), 32'h1000);
    check_eq("postrst_valid", 32'(digit_valid), 32'h8);
    tick(21);

`ifdef SEG7_DP_EN
    dp = 1'b0;
`endif
    show(4'b1011, 7'b0100000, 40);
`ifdef SEG7_DP_EN
    dp = 1'b1;
    check_eq("dp_out", 32'(dp_out), 32'h4);
`endif
    check_eq("dp_digits", 32'(digits_out), 32'h1600);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
